noc_rr_port_scheduler: RTL

- Round-robin scheduler for one router output port in the mesh NoC emulator.
- Shares the port among N_PORTS input terminal FIFOs and sequences each transfer as grant -> push -> pop.
- Reports the active turn and keeps saturating per-input grant counters so benches can check fairness.
- Sits between the per-terminal bus interfaces, which supply pending flags and head data, and the output FIFO, which consumes push and data and asserts backpressure.

---
 rtl/noc_rr_port_scheduler.sv | 119 +++++++++++
 1 files changed

// File: rtl/noc_rr_port_scheduler.sv
// Round-robin scheduler for one NoC router output port.
// Shares the port among N_PORTS input FIFOs, sequencing each transfer as
// grant -> push -> pop, and keeps saturating per-input grant counters.
module noc_rr_port_scheduler #(
   parameter int unsigned PCKG_SZ = 40,
   parameter int unsigned N_PORTS = 4,
   parameter int unsigned TRN_W   = $clog2(N_PORTS),
   parameter int unsigned CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_PORTS-1:0]         pndng_i,
   input  logic [N_PORTS*PCKG_SZ-1:0] data_i,
   input  logic                       out_full_i,
   output logic [TRN_W-1:0]           trn_o,
   output logic                       busy_o,
   output logic                       push_o,
   output logic [PCKG_SZ-1:0]         data_o,
   output logic [N_PORTS-1:0]         pop_o,
   output logic [N_PORTS*CNT_W-1:0]   grant_cnt_o
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      PUSH,
      POP
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [TRN_W-1:0]   ptr_q;
   logic [TRN_W-1:0]   trn_q;
   logic [TRN_W-1:0]   sel_idx;
   logic [TRN_W-1:0]   ptr_nxt;
   logic               req_found;
   logic [PCKG_SZ-1:0] pkt_q;
   logic [PCKG_SZ-1:0] data_q;
   logic [CNT_W-1:0]   cnt_q [N_PORTS];

   // Find the first pending input scanning from ptr with wrap-around.
   always_comb begin : sel_scan
      int unsigned k;
      k         = 0;
      req_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) begin
         k = 32'(ptr_q) + i;
         if (k >= N_PORTS) k = k - N_PORTS;
         if (!req_found && pndng_i[k[TRN_W-1:0]]) begin
            req_found = 1'b1;
            sel_idx   = k[TRN_W-1:0];
         end
      end
   end

   // Pointer value just past the granted input, modulo N_PORTS.
   always_comb begin
      ptr_nxt = '0;
      if (32'(trn_q) + 1 < N_PORTS) ptr_nxt = trn_q + TRN_W'(1);
   end

   // Transfer sequencing: IDLE -> GRANT (waits out backpressure) -> PUSH -> POP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_found) state_d = GRANT;
         GRANT:   if (!out_full_i) state_d = PUSH;
         PUSH:    state_d = POP;
         POP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Turn, latched packet, output data and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trn_q  <= '0;
         pkt_q  <= '0;
         data_q <= '0;
         ptr_q  <= '0;
      end else begin
         if (state_q == IDLE && req_found) begin
            trn_q <= sel_idx;
            pkt_q <= data_i[32'(sel_idx)*PCKG_SZ +: PCKG_SZ];
         end
         if (state_q == GRANT && !out_full_i) data_q <= pkt_q;
         if (state_q == POP) ptr_q <= ptr_nxt;
      end
   end

   // Saturating completed-transfer counters, bumped on the pop cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_PORTS; i++) cnt_q[i] <= '0;
      end else if (state_q == POP && cnt_q[trn_q] != '1) begin
         cnt_q[trn_q] <= cnt_q[trn_q] + CNT_W'(1);
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      busy_o = (state_q != IDLE);
      push_o = (state_q == PUSH);
      pop_o  = '0;
      if (state_q == POP) pop_o[trn_q] = 1'b1;
      trn_o  = trn_q;
      data_o = data_q;
      grant_cnt_o = '0;
      for (int unsigned i = 0; i < N_PORTS; i++) grant_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
   end

endmodule
